// File: rtl/pix_bin2x2.sv
// pix_bin2x2
// 2x2 pixel binning on a {vs, hs, de, pixel} stream. Each output pixel is
// the box average, top-left sample or per-channel maximum of a 2x2 input
// block. Mode 0 passes the stream through unchanged.
// Pipeline: input cycle -> stage 1 (pair/stored capture) -> stage 2 (output).
// A half-width line buffer holds the horizontal pair results of even rows.
module pix_bin2x2 #(
  parameter int CW    = 8,
  parameter int NCH   = 3,
  parameter int H_ACT = 1920,
  parameter int V_ACT = 1080,
  parameter int ROUND = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vs_i,
  input  logic              hs_i,
  input  logic              de_i,
  input  logic [NCH*CW-1:0] pix_i,
  input  logic [1:0]        mode,
  output logic              vs_o,
  output logic              hs_o,
  output logic              de_o,
  output logic [NCH*CW-1:0] pix_o,
  output logic              line_err_o
);

  // Pair results carry one extra bit so a two-sample sum fits.
  localparam int PW    = CW + 1;
  localparam int DEPTH = H_ACT / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COLW  = $clog2(H_ACT + 1);
  localparam int ROWW  = (V_ACT > 1) ? $clog2(V_ACT + 1) : 1;

  localparam logic [COLW-1:0] COL_MAX = '1;
  localparam logic [ROWW-1:0] ROW_MAX = '1;
  localparam logic [COLW-1:0] COL_LIM = COLW'(H_ACT);
  localparam logic [CW+1:0]   RND_ADD = (ROUND != 0) ? (CW+2)'(2) : '0;

  typedef enum logic [1:0] {
    M_BYPASS = 2'd0,
    M_AVG    = 2'd1,
    M_DEC    = 2'd2,
    M_MAX    = 2'd3
  } mode_e;

  mode_e                mode_q;
  logic [COLW-1:0]      col;
  logic [ROWW-1:0]      row;
  logic                 de_q;

  logic [NCH*CW-1:0]    even_q;
  logic [NCH*PW-1:0]    rd_q;
  logic [NCH*PW-1:0]    line_buf [DEPTH];
  logic [NCH*PW-1:0]    p_cur;
  logic [AW-1:0]        buf_addr;
  logic                 in_range;
  logic                 pix_ok;

  logic                 s1_vs;
  logic                 s1_hs;
  logic                 s1_de;
  logic [NCH*CW-1:0]    s1_pix;
  logic                 s1_blk;
  logic [NCH*PW-1:0]    s1_p;
  logic [NCH*PW-1:0]    s1_u;
  mode_e                s1_mode;
  logic [NCH*CW-1:0]    blk_res;

  // Pixels past the line-buffer width are dropped; only reduction modes touch the buffer.
  assign in_range = (col < COL_LIM);
  assign pix_ok   = de_i && in_range && (mode_q != M_BYPASS);
  assign buf_addr = AW'(col >> 1);

  // Horizontal pair result from the held even pixel and the current odd pixel.
  always_comb begin
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    p_cur = '0;
    a     = '0;
    b     = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      a = even_q[ch*CW +: CW];
      b = pix_i[ch*CW +: CW];
      case (mode_q)
        M_AVG:   p_cur[ch*PW +: PW] = {1'b0, a} + {1'b0, b};
        M_MAX:   p_cur[ch*PW +: PW] = {1'b0, (a > b) ? a : b};
        default: p_cur[ch*PW +: PW] = {1'b0, a};
      endcase
    end
  end

  // Frame bookkeeping: mode latch, saturating column/row counters, overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= M_BYPASS;
      col        <= '0;
      row        <= '0;
      de_q       <= 1'b0;
      line_err_o <= 1'b0;
    end else begin
      de_q <= de_i;
      if (vs_i)
        mode_q <= mode_e'(mode);
      if (de_i) begin
        if (col != COL_MAX)
          col <= col + 1'b1;
      end else if (de_q) begin
        col <= '0;
      end
      if (vs_i)
        row <= '0;
      else if (de_q && !de_i && (row != ROW_MAX))
        row <= row + 1'b1;
      if (de_i && !in_range)
        line_err_o <= 1'b1;
      else if (vs_i)
        line_err_o <= 1'b0;
    end
  end

  // Even column: hold the left pixel and, on odd rows, fetch the stored upper pair.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      even_q <= '0;
      rd_q   <= '0;
    end else if (pix_ok && !col[0]) begin
      even_q <= pix_i;
      if (row[0])
        rd_q <= line_buf[buf_addr];
    end
  end

  // Odd column on an even row: store the pair result for the row below.
  always_ff @(posedge clk) begin
    if (rst_n && pix_ok && col[0] && !row[0])
      line_buf[buf_addr] <= p_cur;
  end

  // Stage 1: delay syncs/raw data and capture the current and stored pair results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vs   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_de   <= 1'b0;
      s1_pix  <= '0;
      s1_blk  <= 1'b0;
      s1_p    <= '0;
      s1_u    <= '0;
      s1_mode <= M_BYPASS;
    end else begin
      s1_vs   <= vs_i;
      s1_hs   <= hs_i;
      s1_de   <= de_i;
      s1_pix  <= pix_i;
      s1_mode <= mode_q;
      s1_blk  <= pix_ok && col[0] && row[0];
      if (pix_ok && col[0]) begin
        s1_p <= p_cur;
        s1_u <= rd_q;
      end
    end
  end

  // Vertical combine of the stored (upper) and current (lower) pair results.
  always_comb begin
    logic [PW-1:0] u;
    logic [PW-1:0] p;
    blk_res = '0;
    u       = '0;
    p       = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      u = s1_u[ch*PW +: PW];
      p = s1_p[ch*PW +: PW];
      case (s1_mode)
        M_AVG:   blk_res[ch*CW +: CW] = CW'(({1'b0, u} + {1'b0, p} + RND_ADD) >> 2);
        M_MAX:   blk_res[ch*CW +: CW] = (u > p) ? u[CW-1:0] : p[CW-1:0];
        default: blk_res[ch*CW +: CW] = u[CW-1:0];
      endcase
    end
  end

  // Stage 2: registered outputs; pix_o holds its last block value between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_o  <= 1'b0;
      hs_o  <= 1'b0;
      de_o  <= 1'b0;
      pix_o <= '0;
    end else begin
      vs_o <= s1_vs;
      hs_o <= s1_hs;
      if (s1_mode == M_BYPASS) begin
        de_o  <= s1_de;
        pix_o <= s1_pix;
      end else begin
        de_o <= s1_blk;
        if (s1_blk)
          pix_o <= blk_res;
      end
    end
  end

endmodule
